// File: rtl/cmd_master.sv
// cmd_master: assembles 5-byte command frames from a byte stream, issues each on the engine
// control port and returns a response frame. Define CMD_MASTER_CYCLE_COUNT_EN to append a latency count.
module cmd_master #(
  parameter int unsigned RX_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [2:0]  cmd,
  output logic [31:0] cmd_arg0,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] cmd_res,
  output logic        busy
);

`ifdef CMD_MASTER_CYCLE_COUNT_EN
  localparam int RESP_BYTES = 9;
`else
  localparam int RESP_BYTES = 5;
`endif
  localparam int          SHW       = (RESP_BYTES - 1) * 8;
  localparam logic [15:0] GAP_LIMIT = 16'(RX_TIMEOUT);
  localparam logic [3:0]  LAST_LEFT = 4'(RESP_BYTES - 1);

  typedef enum logic [1:0] {
    S_RX,
    S_ISSUE,
    S_WAIT,
    S_TX
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [23:0]      arg_q, arg_d;
  logic [15:0]      gap_q, gap_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [31:0]      cmd_arg0_q, cmd_arg0_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [SHW-1:0]   tx_shift_q, tx_shift_d;
  logic [3:0]       tx_left_q, tx_left_d;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
  logic [31:0]      lat_q, lat_d, lat_inc;
`endif

  logic        rx_fire;
  logic        tx_fire;
  logic [15:0] gap_inc;

  assign rx_fire = rx_ready_q & rx_valid;
  assign tx_fire = tx_valid_q & tx_ready;
  assign gap_inc = gap_q + 16'd1;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
  assign lat_inc = (lat_q == 32'hFFFF_FFFF) ? lat_q : lat_q + 32'd1;
`endif

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign cmd       = cmd_q;
  assign cmd_arg0  = cmd_arg0_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;

  // Outputs are registered: each state transition also computes the next value of every output.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    opcode_d    = opcode_q;
    arg_d       = arg_q;
    gap_d       = gap_q;
    cmd_d       = cmd_q;
    cmd_arg0_d  = cmd_arg0_q;
    cmd_valid_d = cmd_valid_q;
    rx_ready_d  = rx_ready_q;
    busy_d      = busy_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_shift_d  = tx_shift_q;
    tx_left_d   = tx_left_q;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
    lat_d       = lat_q;
`endif
    case (state_q)
      S_RX: begin
        if (rx_fire) begin
          gap_d = 16'd0;
          case (byte_cnt_q)
            3'd0: begin
              opcode_d   = rx_data;
              byte_cnt_d = 3'd1;
            end
            3'd1, 3'd2, 3'd3: begin
              arg_d      = {arg_q[15:0], rx_data};
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
            default: begin
              byte_cnt_d = 3'd0;
              rx_ready_d = 1'b0;
              busy_d     = 1'b1;
              if (opcode_q[7:3] == 5'd0) begin
                state_d     = S_ISSUE;
                cmd_valid_d = 1'b1;
                cmd_d       = opcode_q[2:0];
                cmd_arg0_d  = {arg_q, rx_data};
              end else begin
                state_d    = S_TX;
                tx_valid_d = 1'b1;
                tx_data_d  = 8'h01;
                tx_shift_d = '0;
                tx_left_d  = LAST_LEFT;
              end
            end
          endcase
        end else if (byte_cnt_q != 3'd0 && GAP_LIMIT != 16'd0) begin
          // A stalled partial frame is dropped silently once the gap reaches the limit.
          if (gap_inc == GAP_LIMIT) begin
            byte_cnt_d = 3'd0;
            gap_d      = 16'd0;
          end else begin
            gap_d = gap_inc;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d     = S_WAIT;
          cmd_valid_d = 1'b0;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
          lat_d       = 32'd0;
`endif
        end
      end
      S_WAIT: begin
`ifdef CMD_MASTER_CYCLE_COUNT_EN
        lat_d = lat_inc;
`endif
        if (cmd_ready) begin
          state_d    = S_TX;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h00;
          tx_left_d  = LAST_LEFT;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
          tx_shift_d = {cmd_res, lat_inc};
`else
          tx_shift_d = cmd_res;
`endif
        end
      end
      S_TX: begin
        if (tx_fire) begin
          if (tx_left_q == 4'd0) begin
            state_d    = S_RX;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            rx_ready_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            tx_data_d  = tx_shift_q[SHW-1 -: 8];
            tx_shift_d = tx_shift_q << 8;
            tx_left_d  = tx_left_q - 4'd1;
          end
        end
      end
      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RX;
      byte_cnt_q  <= 3'd0;
      opcode_q    <= 8'h00;
      arg_q       <= 24'h0;
      gap_q       <= 16'd0;
      cmd_q       <= 3'd0;
      cmd_arg0_q  <= 32'h0;
      cmd_valid_q <= 1'b0;
      rx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_shift_q  <= '0;
      tx_left_q   <= 4'd0;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
      lat_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      opcode_q    <= opcode_d;
      arg_q       <= arg_d;
      gap_q       <= gap_d;
      cmd_q       <= cmd_d;
      cmd_arg0_q  <= cmd_arg0_d;
      cmd_valid_q <= cmd_valid_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_shift_q  <= tx_shift_d;
      tx_left_q   <= tx_left_d;
`ifdef CMD_MASTER_CYCLE_COUNT_EN
      lat_q       <= lat_d;
`endif
    end
  end

endmodule
